// File: rtl/cr16_control_fsm.sv
//------------------------------------------------------------------------------
// cr16_control_fsm
// Multi-cycle FETCH / DECODE / EXEC controller for the CompactRISC16 core.
// Fetches 16-bit instructions over a request/valid handshake, decodes them into
// datapath controls that are valid for one EXEC cycle, owns the program
// counter and resolves conditional branches from the datapath flags.
//
// Optional feature macro: CR16_CTRL_ILLEGAL_TRAP_EN
//   defined   : op D/E halts the core and raises O_ILLEGAL (PC holds).
//   undefined : op D/E executes as a NOP and the O_ILLEGAL port is absent.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module cr16_control_fsm #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    output logic [15:0] O_MEM_ADDR,
    output logic        O_MEM_REQ,
    input  logic [15:0] I_MEM_RDATA,
    input  logic        I_MEM_RVALID,
    input  logic [4:0]  I_FLAGS,
    output logic [15:0] O_REG_ENABLE,
    output logic [3:0]  O_OPCODE,
    output logic        O_ALU_ENABLE,
    output logic [3:0]  O_READ_PORT_A_SEL,
    output logic [3:0]  O_READ_PORT_B_SEL,
    output logic [15:0] O_IMMEDIATE,
    output logic        O_IMM_SEL,
    output logic        O_HALTED
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic        O_ILLEGAL
`endif
);

    // Major opcode values
    localparam logic [3:0] OP_RTYPE      = 4'h0;
    localparam logic [3:0] OP_LAST_LOGIC = 4'h3;
    localparam logic [3:0] OP_LAST_ITYPE = 4'hB;
    localparam logic [3:0] OP_BRANCH     = 4'hC;
    localparam logic [3:0] OP_HALT       = 4'hF;

    // ALU opcode that only updates flags
    localparam logic [3:0] ALU_CMP = 4'hB;

    // Branch condition codes
    localparam logic [3:0] COND_EQ     = 4'h0;
    localparam logic [3:0] COND_NE     = 4'h1;
    localparam logic [3:0] COND_CS     = 4'h2;
    localparam logic [3:0] COND_CC     = 4'h3;
    localparam logic [3:0] COND_LT     = 4'h4;
    localparam logic [3:0] COND_GE     = 4'h5;
    localparam logic [3:0] COND_ALWAYS = 4'hE;

    // Flag bit positions inside I_FLAGS
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } state_t;

    // What the EXEC cycle of the current instruction does to PC and state
    typedef enum logic [2:0] {
        K_ALU,
        K_BRANCH,
        K_HALT,
        K_ILLEGAL,
        K_NOP
    } kind_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc;
    logic [15:0] pc_next;
    logic [15:0] ir;

    // Instruction fields
    logic [3:0]  ir_op;
    logic [3:0]  ir_rd;
    logic [3:0]  ir_ext;
    logic [3:0]  ir_rs;
    logic [7:0]  ir_imm8;
    logic [15:0] imm_ext;
    logic [15:0] rd_onehot;

    // Decoded controls (combinational from IR)
    kind_t       dec_kind;
    logic [3:0]  dec_opcode;
    logic [3:0]  dec_a_sel;
    logic [3:0]  dec_b_sel;
    logic [15:0] dec_imm;
    logic        dec_imm_sel;
    logic        dec_alu_en;
    logic [15:0] dec_reg_en;

    // Control registers latched in DECODE, presented in EXEC
    kind_t       ctl_kind;
    logic [3:0]  ctl_opcode;
    logic [3:0]  ctl_a_sel;
    logic [3:0]  ctl_b_sel;
    logic [15:0] ctl_imm;
    logic        ctl_imm_sel;
    logic        ctl_alu_en;
    logic [15:0] ctl_reg_en;

    logic [3:0]  branch_cond;
    logic        cond_met;
    logic [15:0] pc_plus_one;
    logic [15:0] branch_target;
    logic        in_exec;
    logic        unused_flags;

    assign ir_op   = ir[15:12];
    assign ir_rd   = ir[11:8];
    assign ir_ext  = ir[7:4];
    assign ir_rs   = ir[3:0];
    assign ir_imm8 = ir[7:0];

    // Logical immediates (AND/OR/XOR style ops 1..3) zero-extend; every other
    // user of imm8, including the branch displacement, sign-extends.
    assign imm_ext   = (ir_op >= 4'h1 && ir_op <= OP_LAST_LOGIC) ?
                       {8'h00, ir_imm8} : {{8{ir_imm8[7]}}, ir_imm8};
    assign rd_onehot = 16'h0001 << ir_rd;

    // Condition code travels in the rd field, which is latched as port A select
    assign branch_cond   = ctl_a_sel;
    assign pc_plus_one   = pc + 16'd1;
    assign branch_target = pc + ctl_imm;
    assign in_exec       = (state == ST_EXEC);

    // L and F flags are not used by any branch condition
    assign unused_flags = ^I_FLAGS[2:1];

    // Decode the instruction register into datapath controls
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dec_kind    = K_NOP;
        dec_opcode  = 4'h0;
        dec_a_sel   = ir_rd;
        dec_b_sel   = ir_rs;
        dec_imm     = imm_ext;
        dec_imm_sel = 1'b0;
        dec_alu_en  = 1'b0;
        dec_reg_en  = 16'h0000;
        if (ir_op == OP_RTYPE) begin
            dec_kind   = K_ALU;
            dec_opcode = ir_ext;
            dec_alu_en = 1'b1;
            dec_reg_en = (ir_ext == ALU_CMP) ? 16'h0000 : rd_onehot;
        end else if (ir_op <= OP_LAST_ITYPE) begin
            dec_kind    = K_ALU;
            dec_opcode  = ir_op;
            dec_b_sel   = ir_rd;
            dec_imm_sel = 1'b1;
            dec_alu_en  = 1'b1;
            dec_reg_en  = (ir_op == ALU_CMP) ? 16'h0000 : rd_onehot;
        end else begin
            case (ir_op)
                OP_BRANCH: dec_kind = K_BRANCH;
                OP_HALT:   dec_kind = K_HALT;
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
                default:   dec_kind = K_ILLEGAL;
`else
                default:   dec_kind = K_NOP;
`endif
            endcase
        end
    end

    // Evaluate the branch condition against the flags present during EXEC
    always_comb begin
        cond_met = 1'b0;
        case (branch_cond)
            COND_EQ:     cond_met = I_FLAGS[FLAG_Z];
            COND_NE:     cond_met = ~I_FLAGS[FLAG_Z];
            COND_CS:     cond_met = I_FLAGS[FLAG_C];
            COND_CC:     cond_met = ~I_FLAGS[FLAG_C];
            COND_LT:     cond_met = I_FLAGS[FLAG_N];
            COND_GE:     cond_met = ~I_FLAGS[FLAG_N];
            COND_ALWAYS: cond_met = 1'b1;
            default:     cond_met = 1'b0;
        endcase
    end

    // Next-state and next-PC selection
    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            ST_FETCH: begin
                if (I_MEM_RVALID) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                case (ctl_kind)
                    K_HALT, K_ILLEGAL: begin
                        state_next = ST_HALT;
                    end
                    K_BRANCH: begin
                        state_next = ST_FETCH;
                        pc_next    = cond_met ? branch_target : pc_plus_one;
                    end
                    default: begin
                        state_next = ST_FETCH;
                        pc_next    = pc_plus_one;
                    end
                endcase
            end
            default: begin
                state_next = ST_HALT;
            end
        endcase
    end

    // State, PC and instruction register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state <= ST_FETCH;
            pc    <= RESET_PC;
            ir    <= 16'h0000;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == ST_FETCH && I_MEM_RVALID) begin
                ir <= I_MEM_RDATA;
            end
        end
    end

    // Latch decoded controls during DECODE so they are stable through EXEC
    // NOTE: control registers are reset so every output reads 0 straight out of reset.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            ctl_kind    <= K_NOP;
            ctl_opcode  <= 4'h0;
            ctl_a_sel   <= 4'h0;
            ctl_b_sel   <= 4'h0;
            ctl_imm     <= 16'h0000;
            ctl_imm_sel <= 1'b0;
            ctl_alu_en  <= 1'b0;
            ctl_reg_en  <= 16'h0000;
        end else if (state == ST_DECODE) begin
            ctl_kind    <= dec_kind;
            ctl_opcode  <= dec_opcode;
            ctl_a_sel   <= dec_a_sel;
            ctl_b_sel   <= dec_b_sel;
            ctl_imm     <= dec_imm;
            ctl_imm_sel <= dec_imm_sel;
            ctl_alu_en  <= dec_alu_en;
            ctl_reg_en  <= dec_reg_en;
        end
    end

`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky illegal-op trap flag, cleared only by reset
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            illegal_q <= 1'b0;
        end else if (in_exec && ctl_kind == K_ILLEGAL) begin
            illegal_q <= 1'b1;
        end
    end

    assign O_ILLEGAL = illegal_q;
`endif

    // Fetch request drops the instant reset is asserted, even mid-fetch
    assign O_MEM_ADDR = pc;
    assign O_MEM_REQ  = (state == ST_FETCH) && !I_RESET;

    // Write/ALU strobes are only live in the single EXEC cycle
    assign O_REG_ENABLE      = in_exec ? ctl_reg_en : 16'h0000;
    assign O_ALU_ENABLE      = in_exec & ctl_alu_en;
    assign O_IMM_SEL         = in_exec & ctl_imm_sel;
    assign O_OPCODE          = in_exec ? ctl_opcode : 4'h0;
    assign O_READ_PORT_A_SEL = ctl_a_sel;
    assign O_READ_PORT_B_SEL = ctl_b_sel;
    assign O_IMMEDIATE       = ctl_imm;
    assign O_HALTED          = (state == ST_HALT);

endmodule

// File: tb/tb_cr16_control_fsm.sv
//------------------------------------------------------------------------------
// tb_cr16_control_fsm
// Scoreboard bench: the memory driver issues instructions (directed, then
// random) and pushes expected EXEC controls and next fetch addresses computed
// by an instruction-level reference model; a monitor process pops and compares
// whenever the DUT starts a fetch or reaches the predicted EXEC cycle.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_cr16_control_fsm;

    localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        I_CLK = 1'b0;
    logic        I_RESET = 1'b1;
    logic [15:0] O_MEM_ADDR;
    logic        O_MEM_REQ;
    logic [15:0] I_MEM_RDATA = 16'h0000;
    logic        I_MEM_RVALID = 1'b0;
    logic [4:0]  I_FLAGS = 5'h00;
    logic [15:0] O_REG_ENABLE;
    logic [3:0]  O_OPCODE;
    logic        O_ALU_ENABLE;
    logic [3:0]  O_READ_PORT_A_SEL;
    logic [3:0]  O_READ_PORT_B_SEL;
    logic [15:0] O_IMMEDIATE;
    logic        O_IMM_SEL;
    logic        O_HALTED;
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
    logic        O_ILLEGAL;
`endif

    cr16_control_fsm #(.RESET_PC(RESET_PC)) dut (
        .I_CLK             (I_CLK),
        .I_RESET           (I_RESET),
        .O_MEM_ADDR        (O_MEM_ADDR),
        .O_MEM_REQ         (O_MEM_REQ),
        .I_MEM_RDATA       (I_MEM_RDATA),
        .I_MEM_RVALID      (I_MEM_RVALID),
        .I_FLAGS           (I_FLAGS),
        .O_REG_ENABLE      (O_REG_ENABLE),
        .O_OPCODE          (O_OPCODE),
        .O_ALU_ENABLE      (O_ALU_ENABLE),
        .O_READ_PORT_A_SEL (O_READ_PORT_A_SEL),
        .O_READ_PORT_B_SEL (O_READ_PORT_B_SEL),
        .O_IMMEDIATE       (O_IMMEDIATE),
        .O_IMM_SEL         (O_IMM_SEL),
        .O_HALTED          (O_HALTED)
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
        ,
        .O_ILLEGAL         (O_ILLEGAL)
`endif
    );

    always #5 I_CLK = ~I_CLK;

    typedef struct {
        int          cyc;
        logic [3:0]  opcode;
        logic [3:0]  a_sel;
        logic [3:0]  b_sel;
        logic [15:0] imm;
        logic        imm_sel;
        logic [15:0] reg_en;
        logic        alu_en;
    } exec_t;

    exec_t       exp_q[$];
    logic [15:0] addr_q[$];

    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    // Reference model state
    logic [15:0] m_pc = RESET_PC;
    bit          m_halted = 1'b0;
    bit          m_illegal = 1'b0;

    always @(posedge I_CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge I_CLK);
        #1;
    endtask

    function automatic bit cond_true(input logic [3:0] c, input logic [4:0] f);
        bit z, cy, n;
        z  = f[3];
        cy = f[0];
        n  = f[4];
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction-level model: expected EXEC controls and the PC that follows
    task automatic model_issue(input logic [15:0] w, input logic [4:0] f, input int exec_cyc);
        exec_t e;
        int op, rd, ext, rs, imm8, disp, nxt;
        op   = int'(w[15:12]);
        rd   = int'(w[11:8]);
        ext  = int'(w[7:4]);
        rs   = int'(w[3:0]);
        imm8 = int'(w[7:0]);
        disp = (imm8 >= 128) ? imm8 - 256 : imm8;
        nxt  = (int'(m_pc) + 1) & 'hFFFF;
        e.cyc = exec_cyc;
        e.opcode = 4'h0;
        e.a_sel = 4'h0;
        e.b_sel = 4'h0;
        e.imm = 16'h0000;
        e.imm_sel = 1'b0;
        e.reg_en = 16'h0000;
        e.alu_en = 1'b0;
        if (op == 0) begin
            e.opcode = 4'(ext);
            e.a_sel  = 4'(rd);
            e.b_sel  = 4'(rs);
            e.alu_en = 1'b1;
            e.reg_en = (ext == 11) ? 16'h0000 : (16'h0001 << rd);
        end else if (op <= 11) begin
            e.opcode  = 4'(op);
            e.a_sel   = 4'(rd);
            e.b_sel   = 4'(rd);
            e.imm_sel = 1'b1;
            e.imm     = (op <= 3) ? 16'(imm8) : 16'(disp);
            e.alu_en  = 1'b1;
            e.reg_en  = (op == 11) ? 16'h0000 : (16'h0001 << rd);
        end else if (op == 12) begin
            if (cond_true(4'(rd), f)) nxt = (int'(m_pc) + disp) & 'hFFFF;
        end else if (op == 15) begin
            m_halted = 1'b1;
        end else if (TRAP) begin
            m_halted  = 1'b1;
            m_illegal = 1'b1;
        end
        exp_q.push_back(e);
        if (!m_halted) begin
            addr_q.push_back(16'(nxt));
            m_pc = 16'(nxt);
        end
    endtask

    // Memory driver: wait for a request, stall, then return the instruction
    task automatic serve_one(input logic [15:0] w, input int waits, input logic [4:0] f);
        int guard;
        guard = 0;
        while (!O_MEM_REQ && guard < 100) begin
            I_MEM_RVALID = 1'($urandom_range(0, 1));
            I_MEM_RDATA  = 16'($urandom);
            tick();
            guard++;
        end
        if (!O_MEM_REQ) begin
            check("fetch_request_timeout", 32'(O_MEM_REQ), 32'd1);
            return;
        end
        repeat (waits) begin
            I_MEM_RVALID = 1'b0;
            I_MEM_RDATA  = 16'($urandom);
            tick();
        end
        I_MEM_RVALID = 1'b1;
        I_MEM_RDATA  = w;
        I_FLAGS      = f;
        model_issue(w, f, cyc + 2);
        tick();
        I_MEM_RVALID = 1'b0;
    endtask

    task automatic do_reset(input bit rvalid_during);
        I_RESET      = 1'b1;
        I_MEM_RVALID = rvalid_during;
        I_MEM_RDATA  = 16'($urandom);
        exp_q.delete();
        addr_q.delete();
        m_pc      = RESET_PC;
        m_halted  = 1'b0;
        m_illegal = 1'b0;
        tick();
        tick();
        check("reset_mem_req", 32'(O_MEM_REQ), 32'd0);
        check("reset_mem_addr", 32'(O_MEM_ADDR), 32'(RESET_PC));
        check("reset_ctrl", {O_REG_ENABLE, O_ALU_ENABLE, O_IMM_SEL, O_OPCODE}, 32'd0);
        check("reset_sel_imm", {O_READ_PORT_A_SEL, O_READ_PORT_B_SEL, O_IMMEDIATE}, 32'd0);
        check("reset_halted", 32'(O_HALTED), 32'd0);
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
        check("reset_illegal", 32'(O_ILLEGAL), 32'd0);
`endif
        I_RESET      = 1'b0;
        I_MEM_RVALID = 1'b0;
        addr_q.push_back(RESET_PC);
        tick();
        check("post_reset_sel_imm", {O_READ_PORT_A_SEL, O_READ_PORT_B_SEL, O_IMMEDIATE}, 32'd0);
    endtask

    // After a halting instruction: stay halted with no requests, then restart
    task automatic finish_halt();
        repeat (4) begin
            tick();
            check("halt_no_request", 32'(O_MEM_REQ), 32'd0);
        end
        check("halted", 32'(O_HALTED), 32'd1);
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
        check("illegal_flag", 32'(O_ILLEGAL), 32'(m_illegal));
`endif
        do_reset(1'b0);
    endtask

    // Monitor: compares fetch addresses and EXEC controls against the queues
    initial begin
        logic [15:0] held_addr;
        bit          prev_req;
        exec_t       e;
        held_addr = 16'h0000;
        prev_req  = 1'b0;
        forever begin
            @(negedge I_CLK);
            if (O_MEM_REQ) begin
                if (!prev_req) begin
                    if (addr_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_fetch: got addr 0x%0h, expected no request", O_MEM_ADDR);
                    end else begin
                        held_addr = addr_q.pop_front();
                        check("fetch_addr", 32'(O_MEM_ADDR), 32'(held_addr));
                    end
                end else begin
                    check("fetch_addr_hold", 32'(O_MEM_ADDR), 32'(held_addr));
                end
            end
            prev_req = O_MEM_REQ;
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("exec_cycle_missed", 32'(cyc), 32'(exp_q[0].cyc));
                exp_q.delete(0);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                check("exec_opcode", 32'(O_OPCODE), 32'(e.opcode));
                check("exec_reg_enable", 32'(O_REG_ENABLE), 32'(e.reg_en));
                check("exec_alu_enable", 32'(O_ALU_ENABLE), 32'(e.alu_en));
                check("exec_imm_sel", 32'(O_IMM_SEL), 32'(e.imm_sel));
                if (e.alu_en) begin
                    check("exec_a_sel", 32'(O_READ_PORT_A_SEL), 32'(e.a_sel));
                    check("exec_b_sel", 32'(O_READ_PORT_B_SEL), 32'(e.b_sel));
                end
                if (e.imm_sel) begin
                    check("exec_immediate", 32'(O_IMMEDIATE), 32'(e.imm));
                end
            end else begin
                check("idle_ctrl", {O_REG_ENABLE, O_ALU_ENABLE, O_IMM_SEL, O_OPCODE}, 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        logic [15:0] w;
        do_reset(1'b1);

        // Reset mid-fetch with a valid strobe present: request drops, restart at RESET_PC
        tick();
        tick();
        do_reset(1'b1);

        // Directed program from PC 0
        serve_one(16'h0351, 0, 5'h00);   // R-type op 5: A=3 B=1, write r3
        serve_one(16'h52FF, 0, 5'h00);   // I-type op 5: sign-extended 0xFFFF, write r2
        serve_one(16'h12FF, 0, 5'h00);   // I-type op 1: zero-extended 0x00FF
        serve_one(16'hB300, 0, 5'h00);   // compare: no register write
        serve_one(16'hCE0C, 0, 5'h00);   // always branch PC 4 -> 0x10
        serve_one(16'hC0FE, 0, 5'h08);   // EQ with Z=1 at 0x10 -> 0x0E
        serve_one(16'hCE02, 0, 5'h00);   // 0x0E -> 0x10
        serve_one(16'hC0FE, 0, 5'h17);   // EQ with Z=0 at 0x10 -> 0x11
        serve_one(16'h0351, 3, 5'h00);   // three wait cycles
        serve_one(16'hD000, 0, 5'h00);   // illegal: trap or NOP
        if (m_halted) finish_halt();
        serve_one(16'hF000, 0, 5'h00);   // HALT
        finish_halt();

        // PC wrap: branch back from 0 to 0xFFFF, then 0xFFFF + 1 = 0
        serve_one(16'hCEFF, 0, 5'h00);
        serve_one(16'h1234, 1, 5'h00);
        serve_one(16'h0000, 0, 5'h00);

        // Random instructions, wait states and flags
        for (int i = 0; i < 300; i++) begin
            w = 16'($urandom);
            serve_one(w, int'($urandom_range(0, 3)), 5'($urandom));
            if (m_halted) finish_halt();
        end

        repeat (6) tick();
        check("exec_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cr16_control_fsm.md
# cr16_control_fsm

Multi-cycle instruction controller for the CompactRISC16 core, directly upstream of `cr16_datapath`. It fetches 16-bit instructions from memory over a request/valid handshake and decodes them. It then drives every datapath control input for one execute cycle: register write enables, ALU opcode, read-port selects, immediate and immediate select. It owns the program counter and resolves conditional branches from the datapath's registered flags.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.

Ports:
- `I_CLK`  in  1  system clock; all state updates on rising edge.
- `I_RESET`  in  1  asynchronous, active-high reset.
- `O_MEM_ADDR`  out  16  instruction fetch address (PC).
- `O_MEM_REQ`  out  1  fetch request.
- `I_MEM_RDATA`  in  16  instruction word; valid when `I_MEM_RVALID`=1.
- `I_MEM_RVALID`  in  1  fetch completion strobe.
- `I_FLAGS`  in  5  datapath flag register: [0]=C, [1]=L, [2]=F, [3]=Z, [4]=N.
- `O_REG_ENABLE`  out  16  one-hot register write enable to the datapath.
- `O_OPCODE`  out  4  ALU opcode.
- `O_ALU_ENABLE`  out  1  datapath ALU/flag enable.
- `O_READ_PORT_A_SEL`  out  4  port A register select.
- `O_READ_PORT_B_SEL`  out  4  port B register select.
- `O_IMMEDIATE`  out  16  extended immediate.
- `O_IMM_SEL`  out  1  1 = bus B takes `O_IMMEDIATE`.
- `O_HALTED`  out  1  core stopped.
- `O_ILLEGAL`  out  1  illegal-op trap flag; present only with `CR16_CTRL_ILLEGAL_TRAP_EN`.

## Operation
- Instruction fields: op=IR[15:12], rd=IR[11:8], ext=IR[7:4], rs=IR[3:0], imm8=IR[7:0].
- R-type (op=0):
  - `O_OPCODE`=ext, A_SEL=rd, B_SEL=rs, IMM_SEL=0.
  - Result is written to rd.
- I-type (op 1..B):
  - `O_OPCODE`=op, A_SEL=rd, B_SEL=rd (don't-care), IMM_SEL=1.
  - `O_IMMEDIATE` = zero-extended imm8 for op 1/2/3 (logical ops); sign-extended imm8 for all other I-type ops.
- Compare: ALU opcode 4'hB (R- or I-type) updates flags only; `O_REG_ENABLE`=0.
- All other ALU ops: `O_REG_ENABLE` = 1<<rd.
- Branch (op=C): cond=rd, displacement = sign-extended imm8.
  - Conditions: 0 EQ (Z), 1 NE (!Z), 2 CS (C), 3 CC (!C), 4 LT (N), 5 GE (!N), E always; all others never.
  - Taken: PC <= branch address + disp. Not taken: PC <= branch address + 1.
  - No register write; `O_ALU_ENABLE`=0.
- HALT (op=F): enter HALT.
- op D/E: illegal (see Configuration).
- FSM states:
  - FETCH: `O_MEM_REQ`=1 with `O_MEM_ADDR`=PC, held until `I_MEM_RVALID`=1; then IR <= `I_MEM_RDATA` and go to DECODE.
  - DECODE: register fields latched into control registers; go to EXEC.
  - EXEC: controls valid; `O_ALU_ENABLE`=1 for ALU ops; PC updated; go to FETCH.
  - HALT: absorbing until reset.
- PC arithmetic is 16-bit modulo: 0xFFFF+1 = 0x0000; branch targets wrap the same way.
- Outside EXEC: `O_REG_ENABLE`=0, `O_ALU_ENABLE`=0, `O_IMM_SEL`=0, `O_OPCODE`=0.

## Timing
- Reset (async): PC=`RESET_PC`, state=FETCH, IR=0.
  - All outputs 0, except `O_MEM_ADDR`=`RESET_PC`.
  - `O_MEM_REQ` asserts on the first cycle after reset release.
- Reset asserted mid-fetch: request drops immediately; any in-flight `I_MEM_RVALID` is ignored.
- Minimum 3 cycles per instruction (fetch with zero wait, decode, execute); each memory wait cycle adds one.
- `O_MEM_ADDR` is stable for the whole time `O_MEM_REQ` is high. `I_MEM_RVALID` outside FETCH is ignored.
- The datapath writes the register and flags on the EXEC→FETCH edge. The branch decision uses `I_FLAGS` sampled in EXEC, so it sees the previous instruction's flags.
- `O_HALTED` rises on the cycle after the HALT EXEC; `O_MEM_REQ` stays 0 thereafter.

## Configuration
- `CR16_CTRL_ILLEGAL_TRAP_EN` defined: op D/E enters HALT with `O_ILLEGAL`=1 and `O_HALTED`=1; PC holds the illegal instruction's address.
- Undefined: op D/E executes as NOP (no writes, PC+1); `O_ILLEGAL` port is absent.

## Test plan
- Reset release with `I_MEM_RVALID`=1 constantly -> first `O_MEM_ADDR`=0x0000 with `O_MEM_REQ`=1; all other outputs 0 during and after reset.
- Fetch 0x0351 -> EXEC: `O_OPCODE`=5, A_SEL=3, B_SEL=1, `O_IMM_SEL`=0, `O_REG_ENABLE`=0x0008, `O_ALU_ENABLE`=1; next fetch address 0x0001.
- Fetch 0x52FF, then 0x12FF -> `O_IMMEDIATE`=0xFFFF with `O_REG_ENABLE`=0x0004; then 0x00FF with `O_REG_ENABLE`=0x0004.
- 0xC0FE at PC 0x0010 -> Z=1: next fetch 0x000E; Z=0: next fetch 0x0011. 0xB300 -> `O_REG_ENABLE`=0.
- `I_MEM_RVALID` delayed 3 cycles -> `O_MEM_REQ` and `O_MEM_ADDR` held constant for 4 cycles; EXEC occurs exactly 2 cycles after the valid cycle.
- 0xF000 -> `O_HALTED`=1 and no further requests. 0xD000 with macro -> `O_ILLEGAL`=1, halted. 0xD000 without macro -> NOP and PC+1. Reset during halt -> resumes at 0x0000.
